// File: rtl/d_cache_mem_port_if.sv
`default_nettype none
// ============================================================================
// Module   : d_cache_mem_port_if
// Brief    : Cache-task and d-cache memory-port bundle for d_cache_mem_port.
// Revision : 1.0
// ============================================================================

`ifndef MEM_NOP
`define MEM_NOP           2'b00
`define MEM_READ          2'b01
`define MEM_WRITE         2'b10
`endif
`ifndef MEM_RESTING
`define MEM_RESTING       2'b00
`define MEM_DATA_FINISHED 2'b01
`define MEM_INST_FINISHED 2'b10
`endif
`ifndef ONE_BYTE
`define ONE_BYTE          3'd1
`define TWO_BYTE          3'd2
`define FOUR_BYTE         3'd3
`define EIGHT_BYTE        3'd4
`endif

interface d_cache_mem_port_if #(
  parameter int ADDR_WIDTH       = 17,
  parameter int DATA_LEN         = 32,
  parameter int LINE_WORDS       = 4,
  parameter int ENTRY_INDEX_SIZE = 3
);
  logic                           task_valid;
  logic                           task_ready;
  logic                           task_write;
  logic [ADDR_WIDTH-1:0]          task_addr;
  logic [2:0]                     task_data_type;
  logic [63:0]                    task_wdata;
  logic                           task_done;
  logic [LINE_WORDS*DATA_LEN-1:0] line_data;
  logic [1:0]                     d_cache_mem_vis_signal;
  logic [ADDR_WIDTH-1:0]          d_cache_mem_vis_addr;
  logic [DATA_LEN-1:0]            written_data;
  logic [2:0]                     data_type;
  logic [ENTRY_INDEX_SIZE:0]      length;
  logic [DATA_LEN-1:0]            mem_data;
  logic [1:0]                     mem_status;

  modport master (
    input  task_valid, task_write, task_addr, task_data_type, task_wdata,
    input  mem_data, mem_status,
    output task_ready, task_done, line_data,
    output d_cache_mem_vis_signal, d_cache_mem_vis_addr, written_data, data_type, length
  );

  modport slave (
    output task_valid, task_write, task_addr, task_data_type, task_wdata,
    output mem_data, mem_status,
    input  task_ready, task_done, line_data,
    input  d_cache_mem_vis_signal, d_cache_mem_vis_addr, written_data, data_type, length
  );
endinterface

`default_nettype wire

// File: rtl/d_cache_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : d_cache_mem_port
// Brief    : Splits d-cache line fills and stores into 4-byte memory beats.
// Revision : 1.0
// ============================================================================

module d_cache_mem_port #(
  parameter int ADDR_WIDTH       = 17,
  parameter int DATA_LEN         = 32,
  parameter int LINE_WORDS       = 4,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input wire               clk,
  input wire               rst,
  d_cache_mem_port_if.master bus
);

  localparam int OFF_BITS = $clog2(LINE_WORDS * 4);
  localparam int LEN_W    = ENTRY_INDEX_SIZE + 1;
  localparam int BEAT_W   = ENTRY_INDEX_SIZE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              r_state,  w_state_nx;
  logic [1:0]          r_signal, w_signal_nx;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nx;
  logic [DATA_LEN-1:0] r_wd,     w_wd_nx;
  logic [2:0]          r_dt,     w_dt_nx;
  logic [LEN_W-1:0]    r_len,    w_len_nx;
  logic                r_write,  w_write_nx;
  logic [31:0]         r_wlo,    w_wlo_nx;
  logic [BEAT_W-1:0]   r_beat,   w_beat_nx;
  logic                w_capture;
  logic [ADDR_WIDTH-1:0] w_line_base;

  assign w_line_base = {bus.task_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_signal <= `MEM_NOP;
      r_addr   <= '0;
      r_wd     <= '0;
      r_dt     <= '0;
      r_len    <= '0;
      r_write  <= 1'b0;
      r_wlo    <= '0;
      r_beat   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_signal <= w_signal_nx;
      r_addr   <= w_addr_nx;
      r_wd     <= w_wd_nx;
      r_dt     <= w_dt_nx;
      r_len    <= w_len_nx;
      r_write  <= w_write_nx;
      r_wlo    <= w_wlo_nx;
      r_beat   <= w_beat_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_signal_nx = r_signal;
    w_addr_nx   = r_addr;
    w_wd_nx     = r_wd;
    w_dt_nx     = r_dt;
    w_len_nx    = r_len;
    w_write_nx  = r_write;
    w_wlo_nx    = r_wlo;
    w_beat_nx   = r_beat;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.task_valid) begin
          w_state_nx = REQ;
          w_write_nx = bus.task_write;
          w_wlo_nx   = bus.task_wdata[31:0];
          w_beat_nx  = '0;
          if (bus.task_write) begin
            w_signal_nx = `MEM_WRITE;
            w_addr_nx   = bus.task_addr;
            w_wd_nx     = DATA_LEN'(bus.task_wdata[63:32]);
            // An 8-byte store becomes two 4-byte beats; other sizes pass through.
            if (bus.task_data_type == `EIGHT_BYTE) begin
              w_dt_nx  = `FOUR_BYTE;
              w_len_nx = LEN_W'(2);
            end else begin
              w_dt_nx  = bus.task_data_type;
              w_len_nx = LEN_W'(1);
            end
          end else begin
            w_signal_nx = `MEM_READ;
            w_addr_nx   = w_line_base;
            w_wd_nx     = '0;
            w_dt_nx     = `FOUR_BYTE;
            w_len_nx    = LEN_W'(LINE_WORDS);
          end
        end
      end
      REQ: begin
        if (bus.mem_status == `MEM_DATA_FINISHED) begin
          w_capture   = !r_write;
          w_len_nx    = r_len - LEN_W'(1);
          w_signal_nx = `MEM_NOP;
          w_state_nx  = (r_len > LEN_W'(1)) ? GAP : DONE;
        end
      end
      GAP: begin
        // One NOP cycle lets memory's registered status drop before the next beat.
        w_state_nx  = REQ;
        w_signal_nx = r_write ? `MEM_WRITE : `MEM_READ;
        w_addr_nx   = r_addr + ADDR_WIDTH'(4);
        w_beat_nx   = r_beat + BEAT_W'(1);
        if (r_write) begin
          w_wd_nx = DATA_LEN'(r_wlo);
        end
      end
      DONE: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_line
    logic [DATA_LEN-1:0] r_word;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_word <= '0;
      end else if (w_capture && (r_beat == BEAT_W'(gi))) begin
        r_word <= bus.mem_data;
      end
    end
    assign bus.line_data[gi*DATA_LEN +: DATA_LEN] = r_word;
  end

  assign bus.task_ready             = (r_state == IDLE);
  assign bus.task_done              = (r_state == DONE);
  assign bus.d_cache_mem_vis_signal = r_signal;
  assign bus.d_cache_mem_vis_addr   = r_addr;
  assign bus.written_data           = r_wd;
  assign bus.data_type              = r_dt;
  assign bus.length                 = r_len;

endmodule

`default_nettype wire

// File: tb/tb_d_cache_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_d_cache_mem_port
// Brief    : Self-checking bench with a byte-array memory and task-level model.
// Revision : 1.0
// ============================================================================

`ifndef MEM_NOP
`define MEM_NOP           2'b00
`define MEM_READ          2'b01
`define MEM_WRITE         2'b10
`endif
`ifndef MEM_RESTING
`define MEM_RESTING       2'b00
`define MEM_DATA_FINISHED 2'b01
`define MEM_INST_FINISHED 2'b10
`endif
`ifndef ONE_BYTE
`define ONE_BYTE          3'd1
`define TWO_BYTE          3'd2
`define FOUR_BYTE         3'd3
`define EIGHT_BYTE        3'd4
`endif

module tb_d_cache_mem_port;
  localparam int AW  = 17;
  localparam int DL  = 32;
  localparam int LW  = 4;
  localparam int EIS = 3;
  localparam int MSZ = 1 << AW;
  localparam logic [127:0] PRELOAD = 128'h11223344_55667788_99AABBCC_DDEEFF00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  d_cache_mem_port_if #(.ADDR_WIDTH(AW), .DATA_LEN(DL), .LINE_WORDS(LW), .ENTRY_INDEX_SIZE(EIS)) bus ();

  d_cache_mem_port #(.ADDR_WIDTH(AW), .DATA_LEN(DL), .LINE_WORDS(LW), .ENTRY_INDEX_SIZE(EIS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem     [0:MSZ-1];
  logic [7:0] ref_mem [0:MSZ-1];
  bit mem_inited    = 1'b0;
  int contend_total = 0;
  int contend_used  = 0;

  function automatic logic [7:0] init_byte(input int i);
    if (i >= 32'h1000 && i < 32'h1010) return PRELOAD[127 - 8*(i - 32'h1000) -: 8];
    return 8'(i * 7 + (i >> 8));
  endfunction

  function automatic int nbytes(input logic [2:0] dt);
    case (dt)
      `ONE_BYTE:   return 1;
      `TWO_BYTE:   return 2;
      `EIGHT_BYTE: return 8;
      default:     return 4;
    endcase
  endfunction

  // Memory: registered status, re-executes a held request every cycle.
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < MSZ; i++) mem[i] <= init_byte(i);
      mem_inited     <= 1'b1;
      bus.mem_status <= `MEM_RESTING;
      bus.mem_data   <= '0;
    end else if (bus.d_cache_mem_vis_signal == `MEM_NOP) begin
      bus.mem_status <= `MEM_RESTING;
    end else if (contend_used < contend_total) begin
      bus.mem_status <= `MEM_INST_FINISHED;
      contend_used   <= contend_used + 1;
    end else begin
      bus.mem_status <= `MEM_DATA_FINISHED;
      if (bus.d_cache_mem_vis_signal == `MEM_READ) begin
        bus.mem_data <= {mem[bus.d_cache_mem_vis_addr],
                         mem[bus.d_cache_mem_vis_addr + 17'd1],
                         mem[bus.d_cache_mem_vis_addr + 17'd2],
                         mem[bus.d_cache_mem_vis_addr + 17'd3]};
      end else begin
        for (int k = 0; k < nbytes(bus.data_type) && k < 4; k++)
          mem[bus.d_cache_mem_vis_addr + 17'(k)] <= bus.written_data[31-8*k -: 8];
      end
    end
  end

  typedef struct packed {
    logic [1:0]  sig;
    logic [16:0] addr;
    logic [31:0] wd;
    logic [2:0]  dt;
    logic [3:0]  len;
  } beat_t;

  beat_t cur_b, prev_b;
  beat_t log_a [0:4095];
  int log_cnt   = 0;
  int hold_viol = 0;
  assign cur_b = {bus.d_cache_mem_vis_signal, bus.d_cache_mem_vis_addr, bus.written_data,
                  bus.data_type, bus.length};

  // Logs each newly issued request and counts any change while it is held.
  always @(posedge clk) begin
    if (cur_b.sig != `MEM_NOP) begin
      if (prev_b.sig == `MEM_NOP) begin
        log_a[log_cnt % 4096] <= cur_b;
        log_cnt <= log_cnt + 1;
      end else if (cur_b != prev_b) begin
        hold_viol <= hold_viol + 1;
      end
    end
    prev_b <= cur_b;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_task(input bit wr, input logic [16:0] addr, input logic [2:0] dt,
                          input logic [63:0] wd, input int cont, input bit pulse, input string name);
    beat_t       exp_b [0:7];
    logic [31:0] exp_line [0:3];
    logic [16:0] base;
    int n, base_idx, hv0, cycles, diff, got;
    bit done_seen;
    beat_t g;
    if (!wr) begin
      base = addr & ~17'hF;
      n = LW;
      for (int i = 0; i < LW; i++) begin
        exp_b[i] = {`MEM_READ, 17'(base + 17'(4*i)), 32'h0, `FOUR_BYTE, 4'(LW - i)};
        exp_line[i] = {ref_mem[17'(base + 17'(4*i))], ref_mem[17'(base + 17'(4*i + 1))],
                       ref_mem[17'(base + 17'(4*i + 2))], ref_mem[17'(base + 17'(4*i + 3))]};
      end
    end else if (dt == `EIGHT_BYTE) begin
      n = 2;
      exp_b[0] = {`MEM_WRITE, addr, wd[63:32], `FOUR_BYTE, 4'd2};
      exp_b[1] = {`MEM_WRITE, 17'(addr + 17'd4), wd[31:0], `FOUR_BYTE, 4'd1};
    end else begin
      n = 1;
      exp_b[0] = {`MEM_WRITE, addr, wd[63:32], dt, 4'd1};
    end
    if (wr) for (int k = 0; k < nbytes(dt); k++) ref_mem[17'(addr + 17'(k))] = wd[63-8*k -: 8];

    base_idx = log_cnt;
    hv0 = hold_viol;
    contend_total += cont;

    @(negedge clk);
    bus.task_valid     = 1'b1;
    bus.task_write     = wr;
    bus.task_addr      = addr;
    bus.task_data_type = dt;
    bus.task_wdata     = wd;
    @(posedge clk);
    #1 bus.task_valid = 1'b0;
    chk({name, "_ready_after_accept"}, 64'(bus.task_ready), 64'd0);

    cycles = 0;
    done_seen = 1'b0;
    while (!done_seen && cycles < 400) begin
      @(posedge clk);
      cycles++;
      #1;
      if (pulse && cycles == 4) begin
        bus.task_valid = 1'b1;
        bus.task_write = 1'b1;
        bus.task_addr  = 17'h1ABCD;
        chk({name, "_busy_ready"}, 64'(bus.task_ready), 64'd0);
      end
      if (pulse && cycles == 5) bus.task_valid = 1'b0;
      if (bus.task_done === 1'b1) done_seen = 1'b1;
    end
    chk({name, "_latency"}, 64'(cycles), 64'(3*n - 1 + cont));
    chk({name, "_ready_in_done"}, 64'(bus.task_ready), 64'd0);

    got = log_cnt - base_idx;
    chk({name, "_beats"}, 64'(got), 64'(n));
    for (int i = 0; i < n && i < got; i++) begin
      g = log_a[(base_idx + i) % 4096];
      chk({name, "_beat_sig"},  64'(g.sig),  64'(exp_b[i].sig));
      chk({name, "_beat_addr"}, 64'(g.addr), 64'(exp_b[i].addr));
      chk({name, "_beat_type"}, 64'(g.dt),   64'(exp_b[i].dt));
      chk({name, "_beat_len"},  64'(g.len),  64'(exp_b[i].len));
      if (wr) chk({name, "_beat_wdata"}, 64'(g.wd), 64'(exp_b[i].wd));
    end
    chk({name, "_hold_stable"}, 64'(hold_viol - hv0), 64'd0);

    if (!wr) for (int i = 0; i < LW; i++)
      chk({name, "_line_word"}, 64'(bus.line_data[i*DL +: DL]), 64'(exp_line[i]));

    @(posedge clk);
    #1;
    chk({name, "_done_pulse_width"}, 64'(bus.task_done), 64'd0);
    chk({name, "_ready_back"}, 64'(bus.task_ready), 64'd1);
    chk({name, "_idle_nop"}, 64'(bus.d_cache_mem_vis_signal), 64'(`MEM_NOP));

    diff = 0;
    for (int k = -4; k < 12; k++)
      if (mem[17'(addr + 17'(k))] !== ref_mem[17'(addr + 17'(k))]) diff++;
    chk({name, "_mem_bytes"}, 64'(diff), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    bit wr;
    logic [2:0] dt;
    for (int i = 0; i < MSZ; i++) ref_mem[i] = init_byte(i);
    bus.task_valid     = 1'b0;
    bus.task_write     = 1'b0;
    bus.task_addr      = '0;
    bus.task_data_type = '0;
    bus.task_wdata     = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready",  64'(bus.task_ready), 64'd1);
    chk("reset_done",   64'(bus.task_done), 64'd0);
    chk("reset_signal", 64'(bus.d_cache_mem_vis_signal), 64'(`MEM_NOP));
    chk("reset_len",    64'(bus.length), 64'd0);
    chk("reset_line",   64'(bus.line_data[63:0]), 64'd0);
    @(negedge clk) rst = 1'b0;

    run_task(1'b0, 17'h1006, 3'd0, 64'd0, 0, 1'b0, "fill_1006");
    run_task(1'b1, 17'h2000, `EIGHT_BYTE, 64'h0102030405060708, 0, 1'b0, "store8");
    run_task(1'b1, 17'h2003, `ONE_BYTE, 64'hABCD_EF01_2345_6789, 0, 1'b0, "store1");
    run_task(1'b0, 17'h1040, 3'd0, 64'd0, 5, 1'b0, "fill_contend");
    run_task(1'b0, 17'h0123, 3'd0, 64'd0, 0, 1'b1, "fill_pulse");
    run_task(1'b1, 17'h1FFFE, `EIGHT_BYTE, 64'hCAFEBABE_DEADBEEF, 0, 1'b0, "store8_wrap");
    run_task(1'b0, 17'h2000, 3'd0, 64'd0, 2, 1'b0, "fill_after_store");

    // Reset in the gap between the second and third beats of a fill.
    @(negedge clk);
    bus.task_valid = 1'b1;
    bus.task_write = 1'b0;
    bus.task_addr  = 17'h3004;
    @(posedge clk);
    #1 bus.task_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_signal", 64'(bus.d_cache_mem_vis_signal), 64'(`MEM_NOP));
    chk("rst_mid_addr",   64'(bus.d_cache_mem_vis_addr), 64'd0);
    chk("rst_mid_wdata",  64'(bus.written_data), 64'd0);
    chk("rst_mid_type",   64'(bus.data_type), 64'd0);
    chk("rst_mid_len",    64'(bus.length), 64'd0);
    chk("rst_mid_line_lo", 64'(bus.line_data[63:0]), 64'd0);
    chk("rst_mid_line_hi", 64'(bus.line_data[127:64]), 64'd0);
    chk("rst_mid_done",   64'(bus.task_done), 64'd0);
    chk("rst_mid_ready",  64'(bus.task_ready), 64'd1);
    @(negedge clk) rst = 1'b0;
    bad = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.task_done !== 1'b0 || bus.d_cache_mem_vis_signal !== `MEM_NOP) bad++;
    end
    chk("rst_mid_quiet", 64'(bad), 64'd0);
    run_task(1'b0, 17'h3004, 3'd0, 64'd0, 0, 1'b0, "fill_after_rst");

    for (int t = 0; t < 24; t++) begin
      wr = 1'($urandom_range(0, 1));
      dt = 3'($urandom_range(1, 4));
      run_task(wr, 17'($urandom), dt, {$urandom, $urandom}, int'($urandom_range(0, 3)), 1'b0,
               wr ? "rand_store" : "rand_fill");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/d_cache_mem_port.md
# d_cache_mem_port

Data-side memory initiator between the data cache and main memory. Accepts one cache task at a time, either a full line fill or a store of 1/2/4/8 bytes, and splits it into 4-byte beats on the d-cache memory port. It holds each request until main memory reports completion and returns fill data in memory byte order.

## Interface
Parameters:
- ADDR_WIDTH, 17, byte address width
- DATA_LEN, 32, memory beat width
- LINE_WORDS, 4, words per cache line; power of two, ≤ 2**ENTRY_INDEX_SIZE
- ENTRY_INDEX_SIZE, 3, width of `length` is ENTRY_INDEX_SIZE+1

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- task_valid  in  1  cache task request, sampled only in IDLE
- task_ready  out  1  high only in IDLE
- task_write  in  1  1 = store, 0 = line fill
- task_addr  in  ADDR_WIDTH  byte address
- task_data_type  in  3  `ONE_BYTE/`TWO_BYTE/`FOUR_BYTE/`EIGHT_BYTE (stores only)
- task_wdata  in  64  store data; byte at addr in [63:56], next in [55:48], …
- task_done  out  1  one-cycle pulse at task completion
- line_data  out  LINE_WORDS*DATA_LEN  word i (line base + 4i) at [i*32 +: 32]; byte at lowest address in the word's [31:24]
- d_cache_mem_vis_signal  out  2  `MEM_NOP/`MEM_READ/`MEM_WRITE
- d_cache_mem_vis_addr  out  ADDR_WIDTH  beat address
- written_data  out  DATA_LEN  beat write data, byte at addr in [31:24]
- data_type  out  3  beat size
- length  out  ENTRY_INDEX_SIZE+1  beats remaining, including the current beat
- mem_data  in  DATA_LEN  memory read data
- mem_status  in  2  `MEM_RESTING/`MEM_DATA_FINISHED/`MEM_INST_FINISHED

## Operation
- States: IDLE, REQ, GAP, DONE.
- IDLE:
  - Drive `MEM_NOP.
  - On task_valid, latch all task inputs and go to REQ.
- Beat count:
  - Fill: LINE_WORDS beats of `MEM_READ, `FOUR_BYTE. Base = task_addr with the low log2(LINE_WORDS*4) bits cleared.
  - Store `EIGHT_BYTE: 2 beats of `MEM_WRITE, `FOUR_BYTE. Beat 0 goes to addr with wdata[63:32]; beat 1 goes to addr+4 with wdata[31:0].
  - Store of any other type: 1 beat. data_type is forwarded unchanged and written_data = wdata[63:32]. Unknown types are forwarded as-is; memory reports the error.
- REQ:
  - Hold signal, addr, written_data, data_type and length stable until mem_status == `MEM_DATA_FINISHED is sampled.
  - `MEM_RESTING and `MEM_INST_FINISHED mean keep holding. The i-cache has priority on a concurrent read, so these are not errors.
- Beat completion, on the edge that samples `MEM_DATA_FINISHED:
  - For a read, capture mem_data into line word k.
  - Decrement length.
  - Go to GAP if beats remain, otherwise go to DONE.
- GAP: drive `MEM_NOP for exactly one cycle, then advance the address by 4, load the next beat and go to REQ.
  - The gap is required. Memory re-executes a held request and its status is registered, so without the gap a stale `MEM_DATA_FINISHED would be sampled for the next beat.
  - Duplicate writes of the same beat are harmless.
- DONE:
  - Drive `MEM_NOP, task_done = 1, task_ready = 0.
  - line_data is valid and stays valid until the next fill captures word 0.
  - Next edge goes to IDLE.
- Address arithmetic wraps mod 2**ADDR_WIDTH. Stores are not checked for alignment.
- Reset (asynchronous, valid mid-task):
  - state = IDLE, signal = `MEM_NOP, addr = 0, written_data = 0, data_type = 0, length = 0, line_data = 0, task_done = 0, task_ready = 1.
  - Beats already written are not rolled back.

## Timing
- Request outputs are registered.
- Uncontended beat: issued at edge e, memory executes at e+1, completion sampled at e+2.
- A beat costs 3 cycles including the gap/DONE cycle.
- Task accepted at edge 0 with N beats and no contention: task_done is high in the cycle after edge 3N−1.
  - Fill with LINE_WORDS = 4: done after edge 11.
  - `FOUR_BYTE store: done after edge 2.
  - `EIGHT_BYTE store: done after edge 5.
- Each cycle of i-cache contention adds one cycle.
- The earliest back-to-back accept is the edge after DONE.

## Test plan
- Fill with task_addr = 0x1006, memory words 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00 at 0x1000..0x100C -> four reads at 0x1000/4/8/C with length 4,3,2,1, one NOP between beats, task_done after edge 11, line_data word0 = 0x11223344, word3 = 0xDDEEFF00.
- `EIGHT_BYTE store, addr 0x2000, wdata 0x0102030405060708 -> writes 0x01020304 at 0x2000 then 0x05060708 at 0x2004, task_done after edge 5, memory bytes 01..08 in order.
- `ONE_BYTE store 0xAB… at 0x2003 -> single write, data_type `ONE_BYTE, written_data[31:24] = 0xAB, only byte 0x2003 changes.
- Fill with mem_status held at `MEM_INST_FINISHED for 5 cycles -> request held unchanged, no capture, task_done delayed exactly 5 cycles.
- task_valid pulsed during a fill -> ignored, task_ready = 0; new task accepted only from IDLE.
- rst asserted between beats 1 and 2 of a fill -> outputs immediately `MEM_NOP with all reset values, task_done never pulses, a following fill completes correctly.
